// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one strobe/ready memory port among NUM_CH requesters.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no transaction in flight; pick next pending channel from rr_ptr
//   ST_ISSUE | mem_init high this cycle with the granted slot's fields
//   ST_WAIT  | fields held, waiting for mem_ready to route completion back
module mem_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_init,
    input  logic [3*NUM_CH-1:0]          ch_read_op,
    input  logic [2*NUM_CH-1:0]          ch_write_op,
    input  logic [ADDR_WIDTH*NUM_CH-1:0] ch_addr,
    input  logic [DATA_WIDTH*NUM_CH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]            ch_err,
    output logic                         busy,
    output logic                         mem_init,
    output logic [2:0]                   mem_read_op,
    output logic [1:0]                   mem_write_op,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic                         mem_ready,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0]       pending_q, pending_d;
    logic [RR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]         grant_q, grant_d;

    logic [2:0]              slot_rop_q   [NUM_CH];
    logic [2:0]              slot_rop_d   [NUM_CH];
    logic [1:0]              slot_wop_q   [NUM_CH];
    logic [1:0]              slot_wop_d   [NUM_CH];
    logic [ADDR_WIDTH-1:0]   slot_addr_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0]   slot_addr_d  [NUM_CH];
    logic [DATA_WIDTH-1:0]   slot_wdata_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   slot_wdata_d [NUM_CH];

    logic                    mem_init_q, mem_init_d;
    logic [2:0]              mem_read_op_q, mem_read_op_d;
    logic [1:0]              mem_write_op_q, mem_write_op_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NUM_CH-1:0]       ch_ready_q, ch_ready_d;
    logic [DATA_WIDTH-1:0]   ch_rdata_q, ch_rdata_d;
    logic [NUM_CH-1:0]       ch_err_q, ch_err_d;
    logic                    busy_q, busy_d;

    logic                    arb_found;
    logic [RR_W-1:0]         arb_sel;
    logic [RR_W-1:0]         cand;

    // Round-robin search: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = RR_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!arb_found && pending_q[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    // Next-state: request capture, FSM sequencing and completion routing.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        slot_rop_d     = slot_rop_q;
        slot_wop_d     = slot_wop_q;
        slot_addr_d    = slot_addr_q;
        slot_wdata_d   = slot_wdata_q;
        mem_init_d     = 1'b0;
        mem_read_op_d  = mem_read_op_q;
        mem_write_op_d = mem_write_op_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        ch_ready_d     = '0;
        ch_rdata_d     = ch_rdata_q;
        ch_err_d       = ch_err_q;
        busy_d         = (|pending_q) || (state_q != ST_IDLE);

        // A channel stays pending from capture through its completion cycle,
        // so pending alone tells whether a new strobe is legal.
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_init[i]) begin
                if (pending_q[i]) begin
                    ch_err_d[i] = 1'b1;
                end else begin
                    pending_d[i]    = 1'b1;
                    slot_rop_d[i]   = ch_read_op[3*i +: 3];
                    slot_wop_d[i]   = ch_write_op[2*i +: 2];
                    slot_addr_d[i]  = ch_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                    slot_wdata_d[i] = ch_wdata[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d        = arb_sel;
                    state_d        = ST_ISSUE;
                    mem_init_d     = 1'b1;
                    mem_read_op_d  = slot_rop_q[arb_sel];
                    mem_write_op_d = slot_wop_q[arb_sel];
                    mem_addr_d     = slot_addr_q[arb_sel];
                    mem_wdata_d    = slot_wdata_q[arb_sel];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    ch_rdata_d          = mem_rdata;
                    ch_ready_d[grant_q] = 1'b1;
                    pending_d[grant_q]  = 1'b0;
                    rr_ptr_d            = RR_W'((int'(grant_q) + 1) % NUM_CH);
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            slot_rop_q     <= '{default: '0};
            slot_wop_q     <= '{default: '0};
            slot_addr_q    <= '{default: '0};
            slot_wdata_q   <= '{default: '0};
            mem_init_q     <= 1'b0;
            mem_read_op_q  <= '0;
            mem_write_op_q <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            ch_ready_q     <= '0;
            ch_rdata_q     <= '0;
            ch_err_q       <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            slot_rop_q     <= slot_rop_d;
            slot_wop_q     <= slot_wop_d;
            slot_addr_q    <= slot_addr_d;
            slot_wdata_q   <= slot_wdata_d;
            mem_init_q     <= mem_init_d;
            mem_read_op_q  <= mem_read_op_d;
            mem_write_op_q <= mem_write_op_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            ch_ready_q     <= ch_ready_d;
            ch_rdata_q     <= ch_rdata_d;
            ch_err_q       <= ch_err_d;
            busy_q         <= busy_d;
        end
    end

    assign mem_init     = mem_init_q;
    assign mem_read_op  = mem_read_op_q;
    assign mem_write_op = mem_write_op_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign ch_ready     = ch_ready_q;
    assign ch_rdata     = ch_rdata_q;
    assign ch_err       = ch_err_q;
    assign busy         = busy_q;

endmodule
